// File: rtl/seq_shift_if.sv
// Operand/result bundle between the ALU control unit (master) and the
// multi-cycle SRL/ROL shifter (slave).
interface seq_shift_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             start;
    logic             opcode;
    logic [WIDTH-1:0] data1;
    logic [CNT_W-1:0] data2;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, opcode, data1, data2,
        input  result, busy, done
    );

    modport slave (
        input  start, opcode, data1, data2,
        output result, busy, done
    );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle SRL / ROL shifter, one bit position per clock, START/BUSY/DONE handshake.
// Optional macro SEQ_SHIFT_ZERO_EXIT_EN: SRL finishes early once the value reaches zero.
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    seq_shift_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] FIN   = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             op_r;
    logic             op_next_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] step_s;

    // One-position logical right shift with zero fill.
    function automatic logic [WIDTH-1:0] srl_step(input logic [WIDTH-1:0] v);
        return {1'b0, v[WIDTH-1:1]};
    endfunction

    // One-position rotate left.
    function automatic logic [WIDTH-1:0] rol_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    // Single shift step selected by the opcode latched at START.
    always_comb begin
        step_s = shreg_r;
        if (op_r) begin
            step_s = rol_step(shreg_r);
        end else begin
            step_s = srl_step(shreg_r);
        end
    end

    // Next-state and datapath update for the IDLE -> SHIFT -> FIN sequence.
    always_comb begin
        state_next_s = state_r;
        shreg_next_s = shreg_r;
        cnt_next_s   = cnt_r;
        op_next_s    = op_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    shreg_next_s = bus.data1;
                    cnt_next_s   = bus.data2;
                    op_next_s    = bus.opcode;
                    if (bus.data2 != CNT_ZERO) begin
                        state_next_s = SHIFT;
                    end else begin
                        state_next_s = FIN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                // cnt is at least 1 here, so the decrement cannot wrap
                shreg_next_s = step_s;
                cnt_next_s   = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_next_s = FIN;
`ifdef SEQ_SHIFT_ZERO_EXIT_EN
                end else if (!op_r && (step_s == {WIDTH{1'b0}})) begin
                    state_next_s = FIN;
`endif
                end else begin
                    state_next_s = SHIFT;
                end
            end
            FIN: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; BUSY/DONE registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            op_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            shreg_r <= shreg_next_s;
            cnt_r   <= cnt_next_s;
            op_r    <= op_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == FIN);
        end
    end

    assign bus.result = shreg_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed table, hand-written corner
// sequences and randomized operations against a behavioural model.
module tb_seq_shift_unit;

    logic clk;
    logic reset_n;
    int   passed;
    int   total;

    seq_shift_if #(.WIDTH(8), .CNT_W(3)) bus ();

    seq_shift_unit #(.WIDTH(8), .CNT_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       op;
        int       d;
        int       n;
        int       exp_res;
        int       exp_cyc;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: final value from plain arithmetic on the amount.
    function automatic int model_res(input bit op, input int d, input int n);
        if (op) return ((d << n) | (d >> (8 - n))) & 255;
        return d >> n;
    endfunction

    // Reference: cycle (counted from the START edge) in which DONE is high.
    function automatic int model_cyc(input bit op, input int d, input int n);
        int steps;
        steps = n;
`ifdef SEQ_SHIFT_ZERO_EXIT_EN
        if (!op && n > 0) begin
            for (int m = n; m >= 1; m--) begin
                if ((d >> m) == 0) steps = m;
            end
        end
`endif
        if (n == 0) return 1;
        return steps + 1;
    endfunction

    // Count cycles after the accepting edge until DONE; optionally keep START high with noise.
    task automatic wait_done(input bit hold, output int cyc, output int busy_cnt, output int res);
        cyc = -1;
        busy_cnt = 0;
        res = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                cyc = i;
                res = int'(bus.result);
                return;
            end
            if (hold) begin
                bus.opcode = 1'($urandom);
                bus.data1  = 8'($urandom);
                bus.data2  = 3'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic run_op(input string tag, input bit op, input int d, input int n,
                          input int exp_res, input int exp_cyc);
        int cyc, bc, res;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.data1  = 8'(d);
        bus.data2  = 3'(n);
        @(posedge clk);
        wait_done(1'b0, cyc, bc, res);
        bus.start = 1'b0;
        check({tag, " result"}, res, exp_res);
        check({tag, " done_cycle"}, cyc, exp_cyc);
        check({tag, " busy_cycles"}, bc, exp_cyc);
        @(negedge clk);
        check({tag, " idle_busy"}, int'(bus.busy), 0);
        check({tag, " done_pulse"}, int'(bus.done), 0);
        check({tag, " result_hold"}, int'(bus.result), exp_res);
    endtask

    vec_t vecs[6];

    initial begin
        int cyc, bc, res;
        int d, n, seen;
        bit op;
        passed = 0;
        total  = 0;
        bus.start  = 1'b0;
        bus.opcode = 1'b0;
        bus.data1  = 8'h00;
        bus.data2  = 3'd0;
        reset_n    = 1'b1;

        vecs[0] = '{1'b0, 'hB4, 3, 'h16, 4};
        vecs[1] = '{1'b1, 'h81, 1, 'h03, 2};
        vecs[2] = '{1'b1, 'hA5, 7, 'hD2, 8};
        vecs[3] = '{1'b0, 'h5A, 0, 'h5A, 1};
`ifdef SEQ_SHIFT_ZERO_EXIT_EN
        vecs[4] = '{1'b0, 'h01, 7, 'h00, 2};
`else
        vecs[4] = '{1'b0, 'h01, 7, 'h00, 8};
`endif
        vecs[5] = '{1'b0, 'hF0, 4, 'h0F, 5};

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check("reset result", int'(bus.result), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle no start busy", int'(bus.busy), 0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d, vecs[i].n,
                   vecs[i].exp_res, vecs[i].exp_cyc);
        end

        // START held high with changing operands; back-to-back accept after FIN
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = 1'b0;
        bus.data1  = 8'hF0;
        bus.data2  = 3'd4;
        @(posedge clk);
        wait_done(1'b1, cyc, bc, res);
        check("held result", res, 'h0F);
        check("held done_cycle", cyc, 5);
        bus.opcode = 1'b1;
        bus.data1  = 8'h11;
        bus.data2  = 3'd2;
        @(negedge clk);
        check("post_fin idle busy", int'(bus.busy), 0);
        check("post_fin result hold", int'(bus.result), 'h0F);
        @(posedge clk);
        wait_done(1'b0, cyc, bc, res);
        bus.start = 1'b0;
        check("b2b result", res, 'h44);
        check("b2b done_cycle", cyc, 3);

        // Reset mid-SHIFT aborts without DONE
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = 1'b1;
        bus.data1  = 8'h3C;
        bus.data2  = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("mid busy", int'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort result", int'(bus.result), 0);
        check("abort busy", int'(bus.busy), 0);
        check("abort done", int'(bus.done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("abort no done", seen, 0);
        run_op("after_abort", 1'b1, 'h01, 2, 'h04, 3);

        // Randomized operations against the model
        for (int i = 0; i < 150; i++) begin
            op = 1'($urandom);
            d  = int'($urandom_range(0, 255));
            n  = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            run_op($sformatf("rnd%0d op%0d d%0h n%0d", i, op, d, n),
                   op, d, n, model_res(op, d, n), model_cyc(op, d, n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
